ps2_kbd_ctrl: RTL and testbench

- Consumer-side controller for the ps2_keyboard scan-code FIFO.
- Sequences the ready/nextdata_n pop handshake, one byte at a time.
- Decodes set-2 prefixes: 0xE0 marks an extended key, 0xF0 marks a break (release).
- Tracks the held key, filters typematic repeats, counts presses and latches FIFO overflow.
- Sits between ps2_keyboard and downstream consumers such as the display/ASCII logic in top.

---
 rtl/ps2_kbd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_kbd_ctrl : pops scan codes from the ps2_keyboard FIFO and decodes     |
// |                set-2 make/break/extended sequences into key events.       |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ps2_kbd_ctrl #(
    parameter int REPEAT_FILTER = 1,
    parameter int PREFIX_TO     = 50000,
    parameter int TO_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] data,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_repeat,
    output logic       key_down,
    output logic [7:0] cur_code,
    output logic       cur_ext,
    output logic [7:0] press_cnt,
    output logic       ovf_sticky,
    input  logic       ovf_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TO - 1);

    state_t          state_q,       state_d;
    logic            nextdata_n_q,  nextdata_n_d;
    logic            key_valid_q,   key_valid_d;
    logic [7:0]      key_code_q,    key_code_d;
    logic            key_ext_q,     key_ext_d;
    logic            key_release_q, key_release_d;
    logic            key_repeat_q,  key_repeat_d;
    logic            key_down_q,    key_down_d;
    logic [7:0]      cur_code_q,    cur_code_d;
    logic            cur_ext_q,     cur_ext_d;
    logic [7:0]      press_cnt_q,   press_cnt_d;
    logic            ovf_sticky_q,  ovf_sticky_d;
    logic            ext_pend_q,    ext_pend_d;
    logic            brk_pend_q,    brk_pend_d;
    logic [TO_W-1:0] to_cnt_q,      to_cnt_d;

    logic same_key;
    logic emit;
    logic is_rep;

    // The byte is decoded as it is captured at the POP closing edge, so the
    // GAP-cycle event outputs come straight from flops.
    always_comb begin
        state_d       = state_q;
        nextdata_n_d  = 1'b1;
        key_valid_d   = 1'b0;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_release_d = key_release_q;
        key_repeat_d  = key_repeat_q;
        key_down_d    = key_down_q;
        cur_code_d    = cur_code_q;
        cur_ext_d     = cur_ext_q;
        press_cnt_d   = press_cnt_q;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;
        to_cnt_d      = to_cnt_q;
        same_key      = (data == cur_code_q) && (ext_pend_q == cur_ext_q);
        emit          = 1'b0;
        is_rep        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    state_d      = ST_POP;
                    nextdata_n_d = 1'b0;
                end else if (ext_pend_q || brk_pend_q) begin
                    if (to_cnt_q == TO_LAST) begin
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            ST_POP: begin
                state_d  = ST_GAP;
                to_cnt_d = '0;
                if ((data == 8'h00) || (data == 8'hFF)) begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else if (data == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (data == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (brk_pend_q) begin
                        emit = 1'b1;
                        if (same_key) begin
                            key_down_d = 1'b0;
                        end
                    end else if (key_down_q && same_key) begin
                        is_rep = 1'b1;
                        emit   = (REPEAT_FILTER == 0);
                    end else begin
                        emit        = 1'b1;
                        cur_code_d  = data;
                        cur_ext_d   = ext_pend_q;
                        key_down_d  = 1'b1;
                        press_cnt_d = press_cnt_q + 8'd1;
                    end
                    if (emit) begin
                        key_valid_d   = 1'b1;
                        key_code_d    = data;
                        key_ext_d     = ext_pend_q;
                        key_release_d = brk_pend_q;
                        key_repeat_d  = is_rep;
                    end
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A simultaneous set wins over clear.
        if (overflow) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end else begin
            ovf_sticky_d = ovf_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            nextdata_n_q  <= 1'b1;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_down_q    <= 1'b0;
            cur_code_q    <= 8'h00;
            cur_ext_q     <= 1'b0;
            press_cnt_q   <= 8'h00;
            ovf_sticky_q  <= 1'b0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            nextdata_n_q  <= nextdata_n_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_release_q <= key_release_d;
            key_repeat_q  <= key_repeat_d;
            key_down_q    <= key_down_d;
            cur_code_q    <= cur_code_d;
            cur_ext_q     <= cur_ext_d;
            press_cnt_q   <= press_cnt_d;
            ovf_sticky_q  <= ovf_sticky_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
    assign key_repeat  = key_repeat_q;
    assign key_down    = key_down_q;
    assign cur_code    = cur_code_q;
    assign cur_ext     = cur_ext_q;
    assign press_cnt   = press_cnt_q;
    assign ovf_sticky  = ovf_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_kbd_ctrl : bench for ps2_kbd_ctrl, filtered and unfiltered copies  |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_ps2_kbd_ctrl;

    localparam int PTO = 20;
    localparam int TW  = 5;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ready    = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       overflow = 1'b0;
    logic       ovf_clr  = 1'b0;

    logic       nd_n  [2];
    logic       kv    [2];
    logic [7:0] kcode [2];
    logic       kext  [2];
    logic       krel  [2];
    logic       krep  [2];
    logic       kdown [2];
    logic [7:0] ccode [2];
    logic       cext  [2];
    logic [7:0] pcnt  [2];
    logic       ovf   [2];

    always #5 clk = ~clk;

    // Index 0: repeats filtered; index 1: repeats reported.
    ps2_kbd_ctrl #(.REPEAT_FILTER(1), .PREFIX_TO(PTO), .TO_W(TW)) u_dut_filt (
        .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nd_n[0]), .key_valid(kv[0]), .key_code(kcode[0]),
        .key_ext(kext[0]), .key_release(krel[0]), .key_repeat(krep[0]),
        .key_down(kdown[0]), .cur_code(ccode[0]), .cur_ext(cext[0]),
        .press_cnt(pcnt[0]), .ovf_sticky(ovf[0]), .ovf_clr(ovf_clr)
    );

    ps2_kbd_ctrl #(.REPEAT_FILTER(0), .PREFIX_TO(PTO), .TO_W(TW)) u_dut_rep (
        .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nd_n[1]), .key_valid(kv[1]), .key_code(kcode[1]),
        .key_ext(kext[1]), .key_release(krel[1]), .key_repeat(krep[1]),
        .key_down(kdown[1]), .cur_code(ccode[1]), .cur_ext(cext[1]),
        .press_cnt(pcnt[1]), .ovf_sticky(ovf[1]), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       rep;
        logic [7:0] cnt;
    } ev_t;

    logic [7:0] fifo [$];
    ev_t        log0 [$];
    ev_t        log1 [$];
    int         checks = 0;
    int         errors = 0;
    int         nd_low_cnt = 0;
    int         nd_wide = 0;
    logic       prev_low = 1'b0;

    // Reference model: pop cadence, prefix state, held key and event fields.
    int         lock;
    int         idle_cnt;
    logic       m_nd;
    logic       m_ext, m_brk;
    logic [7:0] m_cur;
    logic       m_cext, m_down;
    logic [7:0] m_cnt;
    logic       m_ovf;
    logic       m_kv    [2];
    logic [7:0] m_kcode [2];
    logic       m_kext  [2];
    logic       m_krel  [2];
    logic       m_krep  [2];

    task automatic model_reset();
        lock = 0; idle_cnt = 0; m_nd = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_cur = 8'h00; m_cext = 1'b0;
        m_down = 1'b0; m_cnt = 8'h00; m_ovf = 1'b0;
        for (int f = 0; f < 2; f++) begin
            m_kv[f] = 1'b0; m_kcode[f] = 8'h00; m_kext[f] = 1'b0;
            m_krel[f] = 1'b0; m_krep[f] = 1'b0;
        end
    endtask

    task automatic emit(input int f, input logic [7:0] b, input logic rel, input logic rep);
        m_kv[f] = 1'b1; m_kcode[f] = b; m_kext[f] = m_ext;
        m_krel[f] = rel; m_krep[f] = rep;
    endtask

    task automatic decode(input logic [7:0] b);
        logic same;
        if (b == 8'h00 || b == 8'hFF) begin
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            same = (b == m_cur) && (m_ext == m_cext);
            if (m_brk) begin
                emit(0, b, 1'b1, 1'b0);
                emit(1, b, 1'b1, 1'b0);
                if (same) m_down = 1'b0;
            end else if (m_down && same) begin
                emit(1, b, 1'b0, 1'b1);
            end else begin
                emit(0, b, 1'b0, 1'b0);
                emit(1, b, 1'b0, 1'b0);
                m_cur = b; m_cext = m_ext; m_down = 1'b1; m_cnt = m_cnt + 8'd1;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic model_step();
        logic popped;
        popped = !m_nd;
        m_kv[0] = 1'b0;
        m_kv[1] = 1'b0;
        if (popped) begin
            if (fifo.size() != 0) void'(fifo.pop_front());
            idle_cnt = 0;
            decode(data);
        end else if ((m_ext || m_brk) && lock == 0 && !ready) begin
            idle_cnt++;
            if (idle_cnt == PTO) begin
                m_ext = 1'b0; m_brk = 1'b0; idle_cnt = 0;
            end
        end
        if (lock == 0 && ready) begin
            m_nd = 1'b0; lock = 2;
        end else begin
            m_nd = 1'b1;
            if (lock > 0) lock--;
        end
        m_ovf = overflow ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    endtask

    function automatic logic [31:0] outv(input int f);
        return {nd_n[f], kv[f], kcode[f], kext[f], krel[f], krep[f],
                kdown[f], ccode[f], cext[f], pcnt[f], ovf[f]};
    endfunction

    function automatic logic [31:0] expv(input int f);
        return {m_nd, m_kv[f], m_kcode[f], m_kext[f], m_krel[f], m_krep[f],
                m_down, m_cur, m_cext, m_cnt, m_ovf};
    endfunction

    task automatic compare();
        ev_t e;
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (outv(f) !== expv(f)) begin
                errors++;
                $display("FAIL outputs dut%0d t=%0t: got %h expected %h", f, $time, outv(f), expv(f));
            end
            if (kv[f] === 1'b1) begin
                e.code = kcode[f]; e.ext = kext[f]; e.rel = krel[f];
                e.rep = krep[f]; e.cnt = pcnt[f];
                if (f == 0) log0.push_back(e); else log1.push_back(e);
            end
        end
        if (nd_n[0] === 1'b0) begin
            nd_low_cnt++;
            if (prev_low) nd_wide++;
        end
        prev_low = (nd_n[0] === 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        @(negedge clk);
        compare();
        #2;
        drive_fifo();
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((fifo.size() != 0 || lock != 0 || !m_nd) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL run_budget: got %0d cycles, limit %0d", n, max);
        end
        repeat (3) tick();
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        nd_low_cnt = 0;
        nd_wide = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) tick();
        chk("reset_dut0", outv(0), 32'h8000_0000);
        chk("reset_dut1", outv(1), 32'h8000_0000);
        rst = 1'b1;
        repeat (2) tick();

        // Press and release of A
        clear_logs();
        push(8'h1C); push(8'hF0); push(8'h1C);
        run(100);
        chk("a_events", log0.size(), 2);
        if (log0.size() >= 2) begin
            chk("a_press", {log0[0].code, log0[0].rel, log0[0].cnt}, {8'h1C, 1'b0, 8'd1});
            chk("a_release", {log0[1].code, log0[1].rel}, {8'h1C, 1'b1});
        end
        chk("a_key_down", kdown[0], 0);
        chk("a_pop_pulses", nd_low_cnt, 3);
        chk("a_pop_width", nd_wide, 0);

        // Extended key
        clear_logs();
        push(8'hE0); push(8'h75);
        run(100);
        chk("ext_held", {cext[0], kdown[0], ccode[0]}, {1'b1, 1'b1, 8'h75});
        push(8'hE0); push(8'hF0); push(8'h75);
        run(100);
        chk("ext_events", log0.size(), 2);
        if (log0.size() >= 2) begin
            chk("ext_press", {log0[0].code, log0[0].ext, log0[0].rel}, {8'h75, 1'b1, 1'b0});
            chk("ext_release", {log0[1].code, log0[1].ext, log0[1].rel}, {8'h75, 1'b1, 1'b1});
        end

        // Typematic repeats
        clear_logs();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        run(100);
        chk("rep_filt_events", log0.size(), 2);
        chk("rep_cnt", pcnt[0], 3);
        chk("rep_unfilt_events", log1.size(), 4);
        if (log1.size() >= 4) begin
            chk("rep_flags", {log1[0].rep, log1[1].rep, log1[2].rep, log1[3].rep}, 4'b0110);
        end

        // Prefix timeout
        clear_logs();
        push(8'hE0);
        run(100);
        repeat (PTO + 2) tick();
        push(8'h1C);
        run(100);
        chk("to_events", log0.size(), 1);
        if (log0.size() >= 1) begin
            chk("to_code_ext", {log0[0].code, log0[0].ext, log0[0].rel}, {8'h1C, 1'b0, 1'b0});
        end

        // Error byte wipes a pending break
        clear_logs();
        push(8'hF0); push(8'h1C); push(8'hF0); push(8'hFF); push(8'h1C);
        run(100);
        chk("err_events", log0.size(), 2);
        if (log0.size() >= 2) begin
            chk("err_press", {log0[1].code, log0[1].rel, log0[1].cnt}, {8'h1C, 1'b0, 8'd5});
        end

        // Sticky overflow
        overflow = 1'b1; tick(); overflow = 1'b0; tick();
        chk("ovf_set", ovf[0], 1);
        repeat (3) tick();
        chk("ovf_hold", ovf[0], 1);
        overflow = 1'b1; ovf_clr = 1'b1; tick(); overflow = 1'b0; ovf_clr = 1'b0; tick();
        chk("ovf_set_wins", ovf[0], 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
        chk("ovf_clear", ovf[0], 0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            int gap;
            r = $urandom_range(0, 15);
            if (r < 6)       push((r % 3 == 0) ? 8'h1C : ((r % 3 == 1) ? 8'h1B : 8'h75));
            else if (r < 8)  push(8'hE0);
            else if (r < 10) push(8'hF0);
            else if (r == 10) push(8'hFF);
            else if (r == 11) push(8'h00);
            else             push(8'($urandom));
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(PTO - 3, PTO + 8) : $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                overflow = ($urandom_range(0, 19) == 0);
                ovf_clr  = ($urandom_range(0, 7) == 0);
                tick();
            end
            overflow = 1'b0;
            ovf_clr  = 1'b0;
        end
        run(5000);

        // Reset during a pop keeps the head byte
        begin
            int n = 0;
            push(8'h1C);
            while (m_nd && n < 20) begin
                tick();
                n++;
            end
            chk("pop_seen", nd_n[0], 0);
            rst = 1'b0;
            #1;
            chk("midpop_rst_dut0", outv(0), 32'h8000_0000);
            chk("midpop_rst_dut1", outv(1), 32'h8000_0000);
            model_reset();
            repeat (2) tick();
            rst = 1'b1;
            clear_logs();
            run(100);
            chk("midpop_events", log0.size(), 1);
            if (log0.size() >= 1) begin
                chk("midpop_repop", {log0[0].code, log0[0].cnt}, {8'h1C, 8'd1});
            end
        end

        // Press counter wrap
        for (int i = 0; i < 254; i++) push((i % 2 == 0) ? 8'h15 : 8'h16);
        run(2000);
        chk("cnt_255", pcnt[0], 255);
        push(8'h15);
        run(100);
        chk("cnt_wrap0", pcnt[0], 0);
        chk("cnt_wrap1", pcnt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
